// File: rtl/rv32i_reg_file.sv
// rv32i_reg_file: RV32I integer register file, x0 hardwired to zero.
//   clk    rising-edge clock for the write port
//   rst    asynchronous active-high reset, clears x1..x31
//   rs1    read port 1 address      rs1_v  read port 1 data (combinational)
//   rs2    read port 2 address      rs2_v  read port 2 data (combinational)
//   rd     write address            rd_v   write data
//   we     write enable (writes to x0 are dropped)
module rv32i_reg_file #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(NREG)-1:0]   rs1,
    input  logic [$clog2(NREG)-1:0]   rs2,
    input  logic [$clog2(NREG)-1:0]   rd,
    output logic [XLEN-1:0]           rs1_v,
    output logic [XLEN-1:0]           rs2_v,
    input  logic [XLEN-1:0]           rd_v,
    input  logic                      we
);

    localparam int unsigned AW = $clog2(NREG);

    // Storage for x1..x(NREG-1); x0 has no flop behind it.
    logic [XLEN-1:0] regs [1:NREG-1];

    // Write port: async clear, otherwise write the addressed register on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (we && (rd == AW'(i))) begin
                    regs[i] <= rd_v;
                end
            end
        end
    end

    // Read ports: address 0 matches no entry, so it falls through to zero.
    always_comb begin
        rs1_v = '0;
        rs2_v = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs1 == AW'(i)) begin
                rs1_v = regs[i];
            end
            if (rs2 == AW'(i)) begin
                rs2_v = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_rv32i_reg_file.sv
// tb_rv32i_reg_file: directed and randomized checks of rv32i_reg_file
// against an array model of the 32 architectural registers.
module tb_rv32i_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] rd_v;
    logic        we;

    logic [31:0] model [32];
    int unsigned n_pass;
    int unsigned n_total;

    rv32i_reg_file dut (
        .clk   (clk),
        .rst   (rst),
        .rs1   (rs1),
        .rs2   (rs2),
        .rd    (rd),
        .rs1_v (rs1_v),
        .rs2_v (rs2_v),
        .rd_v  (rd_v),
        .we    (we)
    );

    // Long period so a full 32-address sweep fits between two edges.
    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        rs1 = a1;
        rs2 = a2;
        #1;
        check($sformatf("%s rs1=%0d", tag, a1), rs1_v, model[a1]);
        check($sformatf("%s rs2=%0d", tag, a2), rs2_v, model[a2]);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 32; a++) begin
            read_check(tag, 5'(a), 5'(31 - a));
        end
    endtask

    task automatic clear_model();
        for (int a = 0; a < 32; a++) model[a] = '0;
    endtask

    // One write cycle: drive at negedge, model follows the architectural rule at posedge.
    task automatic write(input logic [4:0] a, input logic [31:0] v, input logic en);
        @(negedge clk);
        rd   = a;
        rd_v = v;
        we   = en;
        @(posedge clk);
        if (en && !rst && a != 5'd0) model[a] = v;
        #1;
        we = 1'b0;
    endtask

    task automatic write_all();
        for (int i = 1; i < 32; i++) begin
            write(5'(i), 32'hA5A5_0000 + 32'(i), 1'b1);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        clear_model();
        rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; rd_v = '0; we = 1'b0;
        #20;
        sweep("reset");
        @(negedge clk);
        rst = 1'b0;

        // Populate every register and read all back on both ports.
        write_all();
        sweep("write_all");

        // Pulse reset between edges: contents vanish without a clock edge.
        @(negedge clk);
        #5;
        rst = 1'b1;
        clear_model();
        sweep("pulse_rst");
        rst = 1'b0;

        // x0 cannot be written.
        write_all();
        write(5'd0, 32'hFFFF_FFFF, 1'b1);
        read_check("x0_protect", 5'd0, 5'd0);

        // we=0 leaves the target untouched.
        write(5'd5, 32'hDEAD_BEEF, 1'b0);
        read_check("we_low", 5'd5, 5'd5);
        check("we_low reg5 literal", rs1_v, 32'hA5A5_0005);

        // Read during write: old value before the edge, new value after.
        write(5'd7, 32'h1, 1'b1);
        @(negedge clk);
        rs1 = 5'd7; rs2 = 5'd7; rd = 5'd7; rd_v = 32'h2; we = 1'b1;
        #1;
        check("rdw before rs1", rs1_v, 32'h1);
        check("rdw before rs2", rs2_v, 32'h1);
        @(posedge clk);
        model[7] = 32'h2;
        #1;
        we = 1'b0;
        check("rdw after rs1", rs1_v, 32'h2);
        check("rdw after rs2", rs2_v, 32'h2);

        // Async reset mid-run; writes are ignored while it is held.
        @(negedge clk);
        #10;
        rst = 1'b1;
        clear_model();
        sweep("mid_rst");
        write(5'd3, 32'h1234_5678, 1'b1);
        read_check("write_in_rst", 5'd3, 5'd3);
        // Release just before an edge with we=1: that write lands.
        @(negedge clk);
        rd = 5'd9; rd_v = 32'hCAFE_F00D; we = 1'b1;
        #45;
        rst = 1'b0;
        @(posedge clk);
        model[9] = 32'hCAFE_F00D;
        #1;
        we = 1'b0;
        read_check("release_write", 5'd9, 5'd9);
        check("release_write literal", rs1_v, 32'hCAFE_F00D);
        write(5'd11, 32'h0BAD_C0DE, 1'b1);
        read_check("resume", 5'd11, 5'd9);

        // Random traffic: reads checked before and after each edge.
        for (int n = 0; n < 300; n++) begin
            logic [4:0]  a;
            logic [4:0]  b;
            logic [4:0]  w;
            logic [31:0] v;
            logic        e;
            a = 5'($urandom_range(31));
            b = 5'($urandom_range(31));
            w = 5'($urandom_range(31));
            v = $urandom;
            e = 1'($urandom_range(1));
            @(negedge clk);
            rd = w; rd_v = v; we = e;
            read_check("rand_pre", a, b);
            @(posedge clk);
            if (e && w != 5'd0) model[w] = v;
            #1;
            we = 1'b0;
            read_check("rand_post", w, a);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
